aes_block_packer: RTL and testbench

//   Upstream feeder for the AES encrypt/decrypt datapath. Accepts a byte stream over a

---
 rtl/aes_pkg.sv | 7 +
 rtl/aes_block_packer.sv | 90 +++++++++
 tb/tb_aes_block_packer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES block sizing constants and block packer state type
package aes_pkg;
   localparam int AES_BLOCK_BYTES = 16;
   localparam int AES_BLOCK_W = 128;
   localparam logic [7:0] PKCS7_FULL_PAD = 8'h10;
   typedef enum logic [1:0] {FILL, FULL, PAD} packer_state_t;
endpackage

// File: rtl/aes_block_packer.sv
// aes_block_packer: packs a byte stream into 128-bit AES blocks with optional PKCS#7 padding
module aes_block_packer
   import aes_pkg::*;
#(
   parameter bit PAD_EN = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [7:0]             in_byte,
   input  logic                   in_valid,
   input  logic                   in_last,
   output logic                   in_ready,
   output logic [AES_BLOCK_W-1:0] blk_data,
   output logic                   blk_valid,
   output logic                   blk_last,
   input  logic                   blk_ready
);
   packer_state_t          r_state;
   logic [3:0]             r_cnt;
   logic [AES_BLOCK_W-1:0] r_acc;
   logic [AES_BLOCK_W-1:0] r_data;
   logic                   r_valid;
   logic                   r_last;
   logic                   r_pad_pend;
   logic [AES_BLOCK_W-1:0] w_blk;
   logic                   w_wrap;
   logic                   w_done;
   logic [6:0]             w_lo;
   logic [7:0]             w_pad;

   assign in_ready  = (r_state == FILL);
   assign blk_data  = r_data;
   assign blk_valid = r_valid;
   assign blk_last  = r_last;
   assign w_wrap    = (r_cnt == 4'd15);
   assign w_done    = w_wrap || in_last;
   // lane cnt occupies bits [127-8*cnt -: 8], i.e. low bit 8*(15-cnt)
   assign w_lo      = {~r_cnt, 3'b000};
   // 15-cnt pad bytes remain after the byte in lane cnt
   assign w_pad     = PAD_EN ? {4'h0, ~r_cnt} : 8'h00;

   // Merge the incoming byte into the accumulator and fill the tail when the message ends early
   always_comb begin
      w_blk = r_acc;
      w_blk[w_lo +: 8] = in_byte;
      for (int i = 0; i < AES_BLOCK_BYTES; i++)
         if (in_last && i > int'(r_cnt)) w_blk[8*(AES_BLOCK_BYTES-1-i) +: 8] = w_pad;
   end

   // Fill / present / extra-pad-block state machine with registered block outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= FILL;
         r_cnt      <= 4'd0;
         r_acc      <= '0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_last     <= 1'b0;
         r_pad_pend <= 1'b0;
      end else begin
         case (r_state)
            FILL: if (in_valid) begin
               r_acc <= w_blk;
               r_cnt <= w_done ? 4'd0 : r_cnt + 4'd1;
               if (w_done) begin
                  r_state    <= FULL;
                  r_data     <= w_blk;
                  r_valid    <= 1'b1;
                  r_last     <= in_last && !(PAD_EN && w_wrap);
                  r_pad_pend <= in_last && PAD_EN && w_wrap;
               end
            end
            FULL: if (blk_ready) begin
               r_state <= r_pad_pend ? PAD : FILL;
               r_valid <= r_pad_pend;
               if (r_pad_pend) begin
                  r_data     <= {AES_BLOCK_BYTES{PKCS7_FULL_PAD}};
                  r_last     <= 1'b1;
                  r_pad_pend <= 1'b0;
               end
            end
            PAD: if (blk_ready) begin
               r_state <= FILL;
               r_valid <= 1'b0;
            end
            default: r_state <= FILL;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_block_packer.sv
// tb_aes_block_packer: randomized and directed scoreboard bench for both padding modes
module tb_aes_block_packer;
   logic         clk = 1'b0;
   logic         rst_n;
   logic [7:0]   in_byte   [2];
   logic         in_valid  [2];
   logic         in_last   [2];
   logic         in_ready  [2];
   logic [127:0] blk_data  [2];
   logic         blk_valid [2];
   logic         blk_last  [2];
   logic         blk_ready [2];
   int           n_chk = 0;
   int           n_pass = 0;
   logic [128:0] exp_q [2][$];
   logic [128:0] rx_q  [2][$];
   logic [7:0]   cur_q [2][$];
   bit           hold [2];
   bit           expv [2];
   logic [128:0] hold_v [2];
   bit           rdy_rand = 1'b0;

   always #5 clk = ~clk;

   // instance 0: zero-fill, instance 1: PKCS#7
   aes_block_packer #(.PAD_EN(1'b0)) u_zero (
      .clk(clk), .rst_n(rst_n), .in_byte(in_byte[0]), .in_valid(in_valid[0]), .in_last(in_last[0]),
      .in_ready(in_ready[0]), .blk_data(blk_data[0]), .blk_valid(blk_valid[0]), .blk_last(blk_last[0]),
      .blk_ready(blk_ready[0]));
   aes_block_packer #(.PAD_EN(1'b1)) u_pad (
      .clk(clk), .rst_n(rst_n), .in_byte(in_byte[1]), .in_valid(in_valid[1]), .in_last(in_last[1]),
      .in_ready(in_ready[1]), .blk_data(blk_data[1]), .blk_valid(blk_valid[1]), .blk_last(blk_last[1]),
      .blk_ready(blk_ready[1]));

   task automatic chk(input string nm, input logic [128:0] got, input logic [128:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, got, want);
   endtask

   // Block from the buffered message bytes: data first, then the pad byte value or zeros
   function automatic logic [128:0] pack(input int k, input bit last);
      logic [127:0] b = '0;
      int n = cur_q[k].size();
      logic [7:0] p = (k == 1) ? 8'(16 - n) : 8'h00;
      for (int i = 0; i < 16; i++) b = {b[119:0], (i < n) ? cur_q[k][i] : p};
      return {last, b};
   endfunction

   task automatic model_byte(input int k, input logic [7:0] b, input bit l);
      bit full;
      cur_q[k].push_back(b);
      full = (cur_q[k].size() == 16);
      if (full || l) begin
         expv[k] = 1'b1;
         exp_q[k].push_back(pack(k, l && !(k == 1 && full)));
         if (l && k == 1 && full) exp_q[k].push_back({1'b1, {16{8'h10}}});
         cur_q[k].delete();
      end
   endtask

   // Per-cycle checks and scoreboard, sampled on the falling edge
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            exp_q[k].delete();
            cur_q[k].delete();
            hold[k] = 1'b0;
            expv[k] = 1'b0;
         end else begin
            chk("in_ready_vs_valid", 129'(in_ready[k]), 129'(!blk_valid[k]));
            if (expv[k]) chk("valid_latency", 129'(blk_valid[k]), 129'(1));
            expv[k] = 1'b0;
            if (hold[k]) chk("hold_stable", {blk_last[k], blk_data[k]}, hold_v[k]);
            hold[k] = blk_valid[k] && !blk_ready[k];
            hold_v[k] = {blk_last[k], blk_data[k]};
            if (blk_valid[k] && blk_ready[k]) begin
               rx_q[k].push_back({blk_last[k], blk_data[k]});
               if (exp_q[k].size() == 0) begin
                  n_chk++;
                  $display("FAIL unexpected_block inst%0d: got %h expected none", k, {blk_last[k], blk_data[k]});
               end else chk("block", {blk_last[k], blk_data[k]}, exp_q[k].pop_front());
            end
            if (in_valid[k] && in_ready[k]) model_byte(k, in_byte[k], in_last[k]);
         end
      end
   end

   // Random back-pressure on the block side when enabled
   initial forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) for (int k = 0; k < 2; k++) blk_ready[k] = 1'($urandom_range(0, 1));
   end

   task automatic send(input int k, input logic [7:0] b, input bit l, input bit gap);
      int t = 0;
      if (gap) repeat ($urandom_range(0, 2)) begin
         in_valid[k] = 1'b0;
         in_last[k] = 1'($urandom_range(0, 1));
         in_byte[k] = 8'($urandom);
         @(posedge clk);
         #1;
      end
      in_byte[k] = b;
      in_last[k] = l;
      in_valid[k] = 1'b1;
      while (!in_ready[k] && t < 400) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 400) begin
         n_chk++;
         $display("FAIL send_timeout inst%0d: in_ready 0 expected 1", k);
      end else begin
         @(posedge clk);
         #1;
      end
      in_valid[k] = 1'b0;
      in_last[k] = 1'b0;
   endtask

   task automatic send_msg(input int k, input int n, input logic [7:0] base, input logic [7:0] step,
                           input bit rnd, input bit last);
      for (int i = 0; i < n; i++)
         send(k, rnd ? 8'($urandom) : 8'(base + 8'(i) * step), last && i == n - 1, rnd);
   endtask

   task automatic both(input int n, input logic [7:0] base, input logic [7:0] step, input bit rnd, input bit last);
      fork
         send_msg(0, n, base, step, rnd, last);
         send_msg(1, n, base, step, rnd, last);
      join
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || blk_valid[0] || blk_valid[1]) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 3000) begin
         n_chk++;
         $display("FAIL drain_timeout: pending %0d/%0d blocks expected 0", exp_q[0].size(), exp_q[1].size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rx();
      rx_q[0].delete();
      rx_q[1].delete();
   endtask

   task automatic chk_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         chk({tag, "_valid"}, 129'(blk_valid[k]), 129'(0));
         chk({tag, "_last"}, 129'(blk_last[k]), 129'(0));
         chk({tag, "_data"}, 129'(blk_data[k]), 129'(0));
         chk({tag, "_in_ready"}, 129'(in_ready[k]), 129'(1));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid[k] = 1'b0;
         in_last[k] = 1'b0;
         in_byte[k] = 8'h00;
         blk_ready[k] = 1'b1;
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk);
      #1;
      // full 16-byte message in both modes
      clear_rx();
      both(16, 8'h00, 8'h11, 1'b0, 1'b1);
      drain();
      chk("t1_count", 129'(rx_q[0].size()), 129'(1));
      chk("t1_block", rx_q[0][0], {1'b1, 128'h00112233445566778899aabbccddeeff});
      chk("t2_count", 129'(rx_q[1].size()), 129'(2));
      chk("t2_data", rx_q[1][0], {1'b0, 128'h00112233445566778899aabbccddeeff});
      chk("t2_pad", rx_q[1][1], {1'b1, {16{8'h10}}});
      // short message
      clear_rx();
      both(3, 8'h61, 8'h01, 1'b0, 1'b1);
      drain();
      chk("t3_zero", rx_q[0][0], {1'b1, 128'h6162_6300_0000_0000_0000_0000_0000_0000});
      chk("t3_pkcs7", rx_q[1][0], {1'b1, 128'h6162_630d_0d0d_0d0d_0d0d_0d0d_0d0d_0d0d});
      // back-pressure hold
      clear_rx();
      blk_ready[0] = 1'b0;
      blk_ready[1] = 1'b0;
      both(16, 8'h20, 8'h03, 1'b0, 1'b1);
      repeat (10) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            chk("t4_in_ready", 129'(in_ready[k]), 129'(0));
            chk("t4_valid", 129'(blk_valid[k]), 129'(1));
         end
      end
      @(posedge clk);
      #1;
      blk_ready[0] = 1'b1;
      blk_ready[1] = 1'b1;
      drain();
      chk("t4_count", 129'(rx_q[1].size()), 129'(2));
      // reset mid-block discards the partial bytes
      send_msg(0, 7, 8'h40, 8'h01, 1'b0, 1'b0);
      fork
         send_msg(1, 7, 8'h40, 8'h01, 1'b0, 1'b0);
      join
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk_zero("t5_reset");
      @(posedge clk);
      #1;
      clear_rx();
      both(16, 8'ha0, 8'h01, 1'b0, 1'b1);
      drain();
      chk("t5_zero", rx_q[0][0], {1'b1, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf});
      chk("t5_pkcs7", rx_q[1][0], {1'b0, 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf});
      // random gaps and back-pressure
      clear_rx();
      rdy_rand = 1'b1;
      both(32, 8'h00, 8'h00, 1'b1, 1'b1);
      drain();
      chk("t6_zero_count", 129'(rx_q[0].size()), 129'(2));
      chk("t6_pkcs7_count", 129'(rx_q[1].size()), 129'(3));
      for (int m = 0; m < 8; m++) begin
         both($urandom_range(1, 40), 8'h00, 8'h00, 1'b1, 1'b1);
         drain();
      end
      rdy_rand = 1'b0;
      @(posedge clk);
      #1;
      blk_ready[0] = 1'b1;
      blk_ready[1] = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
